// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset hold, load-use stall, branch flush, dmem freeze with timeout.
// Optional perf counters (stall_cycles, flush_count) are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_W     = 4,
    parameter int RESET_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read_EX,
    input  logic [4:0]       reg_dst_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             branch_taken_ID,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready_MEM,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic             timeout_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    // state | meaning
    // HOLD  | fixed post-reset interval, pipeline frozen with bubbles
    // RUN   | normal operation, hazards resolved combinationally
    // MWAIT | data memory outstanding, pipeline frozen until ready/timeout
    localparam logic [1:0] ST_HOLD  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_MWAIT = 2'b10;

    localparam int HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic lu;
    logic frz;
    logic in_pipe;

    assign lu = mem_read_EX && (reg_dst_EX != 5'd0) &&
                ((reg_dst_EX == rs_ID) || (reg_dst_EX == rt_ID));

    assign in_pipe = (state_q == ST_RUN) || (state_q == ST_MWAIT);

    assign frz = ((state_q == ST_RUN) && dmem_req_MEM && !dmem_ready_MEM) ||
                 ((state_q == ST_MWAIT) && !dmem_ready_MEM && (wait_cnt_q != WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (dmem_req_MEM && !dmem_ready_MEM) begin
                    state_d    = ST_MWAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MWAIT: begin
                if (dmem_ready_MEM) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    // timeout: this cycle advances as though memory had answered
                    state_d       = ST_RUN;
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_write   = 1'b0;
        idex_bubble  = 1'b1;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        if (in_pipe) begin
            if (frz) begin
                idex_bubble  = 1'b0;
                memwb_bubble = 1'b1;
            end else if (lu) begin
                // load moves on to MEM while the dependent stays in ID
                idex_write   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_write  = 1'b1;
                memwb_bubble = 1'b0;
            end else begin
                pc_write     = 1'b1;
                ifid_write   = 1'b1;
                idex_write   = 1'b1;
                idex_bubble  = 1'b0;
                exmem_write  = 1'b1;
                memwb_bubble = 1'b0;
                ifid_flush   = branch_taken_ID;
            end
        end
    end

    assign state       = state_q;
    assign timeout_err = timeout_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (in_pipe && (frz || lu) && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (ifid_flush && !(&flush_count_q))
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then randomized traffic against a cycle model.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT   = 3;
    localparam int WAIT_W     = 4;
    localparam int RESET_HOLD = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_read_EX = 1'b0;
    logic [4:0] reg_dst_EX = '0, rs_ID = '0, rt_ID = '0;
    logic branch_taken_ID = 1'b0, dmem_req_MEM = 1'b0, dmem_ready_MEM = 1'b0;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic exmem_write, memwb_bubble, timeout_err;
    logic [1:0] state;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    pipe_hazard_ctrl #(
        .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .RESET_HOLD(RESET_HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_EX(mem_read_EX), .reg_dst_EX(reg_dst_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .branch_taken_ID(branch_taken_ID),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ready_MEM(dmem_ready_MEM),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .state(state), .timeout_err(timeout_err)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] outs;
        int         stalls;
        int         flushes;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int cycle_no = 0;

    // reference model: mode 0 hold, 1 run, 2 waiting on memory
    int m_mode = 0;
    int m_hold_elapsed = 0;
    int m_waited = 0;
    bit m_err = 0;
    int m_stalls = 0;
    int m_flushes = 0;

    task automatic model_reset();
        m_mode = 0; m_hold_elapsed = 0; m_waited = 0; m_err = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    task automatic drive_cycle(input bit rst_v, input bit mr, input int rd, input int rs,
                               input int rt, input bit br, input bit req, input bit rdy);
        bit lu, frz, flush;
        bit [6:0] ctl;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst_v;
        mem_read_EX = mr; reg_dst_EX = 5'(rd); rs_ID = 5'(rs); rt_ID = 5'(rt);
        branch_taken_ID = br; dmem_req_MEM = req; dmem_ready_MEM = rdy;
        if (!rst_v) model_reset();
        lu  = mr && rd != 0 && (rd == rs || rd == rt);
        frz = (m_mode == 1 && req && !rdy) || (m_mode == 2 && !rdy && m_waited != MAX_WAIT);
        flush = 0;
        // {pc, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b}
        if (m_mode == 0)  ctl = 7'b0000101;
        else if (frz)     ctl = 7'b0000001;
        else if (lu)      ctl = 7'b0001110;
        else if (br) begin ctl = 7'b1111010; flush = 1; end
        else              ctl = 7'b1101010;
        e.outs = {ctl, 2'(m_mode), m_err};
        e.stalls = m_stalls;
        e.flushes = m_flushes;
        e.cyc = cycle_no;
        exp_q.push_back(e);
        cycle_no++;
        if (rst_v) begin
            if (m_mode != 0 && (frz || lu) && m_stalls < CNT_MAX) m_stalls++;
            if (flush && m_flushes < CNT_MAX) m_flushes++;
            case (m_mode)
                0: begin
                    m_hold_elapsed++;
                    if (m_hold_elapsed >= RESET_HOLD) begin m_mode = 1; m_hold_elapsed = 0; end
                end
                1: if (req && !rdy) begin m_mode = 2; m_waited = 1; end
                default: begin
                    if (rdy) begin m_mode = 1; m_waited = 0; end
                    else if (m_waited == MAX_WAIT) begin m_mode = 1; m_waited = 0; m_err = 1; end
                    else m_waited++;
                end
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                       exmem_write, memwb_bubble, state, timeout_err};
                checks++;
                if (act !== e.outs) begin
                    failures++;
                    $display("FAIL ctrl_outputs cycle=%0d actual=%b expected=%b", e.cyc, act, e.outs);
                end
`ifdef HAZ_PERF_CNT_EN
                checks++;
                if (stall_cycles !== CNT_W'(e.stalls) || flush_count !== CNT_W'(e.flushes)) begin
                    failures++;
                    $display("FAIL perf_counters cycle=%0d actual=%0d/%0d expected=%0d/%0d",
                             e.cyc, stall_cycles, flush_count, e.stalls, e.flushes);
                end
`endif
            end
        end
    end

    initial begin : stimulus
        int len;
        // reset 3 cycles, then hold interval and first RUN cycles
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // load-use, then reg 0 destination which must not stall
        drive_cycle(1, 1, 8, 8, 3, 0, 0, 0);
        idle(1);
        drive_cycle(1, 1, 0, 0, 0, 0, 0, 0);
        // 3 cycles not ready then ready (stays under timeout with MAX_WAIT=3)
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // timeout: ready held low
        for (int i = 0; i < 6; i++) drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // branch together with lu, then branch alone
        drive_cycle(1, 1, 5, 2, 5, 1, 0, 0);
        drive_cycle(1, 0, 5, 2, 5, 1, 0, 0);
        idle(1);
        // long stall run to saturate the stall counter, then reset mid-wait
        for (int i = 0; i < 20; i++) drive_cycle(1, 1, 7, 7, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        // randomized traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++)
                    drive_cycle(0, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                                $urandom_range(0, 1));
            end else begin
                drive_cycle(1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), ($urandom_range(0, 9) < 3),
                            ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4));
            end
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
